// File: rtl/vce_palette_huc6260.sv
// rtl/vce_palette_huc6260.sv - HuC6260 colour encoder: CPU register port, colour table RAM, pixel-to-RGB pipeline
module vce_palette_huc6260 #(
    parameter int PIPE_LAT = 2,
    parameter int CT_DEPTH = 512
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       CS_n,
    input  logic       WR_n,
    input  logic       RD_n,
    input  logic [2:0] A,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic [8:0] VD,
    input  logic       HSYNC_n,
    input  logic       VSYNC_n,
    output logic [2:0] R,
    output logic [2:0] G,
    output logic [2:0] B,
    output logic       HSYNC_out_n,
    output logic       VSYNC_out_n,
    output logic [1:0] DCC
);

    localparam int AW = $clog2(CT_DEPTH);

    logic [8:0]    ctram [CT_DEPTH];
    logic [AW-1:0] cta;
    logic [AW-1:0] cta_next;
    logic [7:0]    lo_stage;
    logic [7:0]    cr;
    logic          wr_prev;
    logic          rd_prev;
    logic          wr_ev;
    logic          rd_ev;
    logic          ct_we;
    logic [8:0]    ram_b_q;
    logic [8:0]    rd_latch;
    logic [8:0]    vd_idx;
    logic [8:0]    pix_c;
    logic          blank_q;
    logic [PIPE_LAT-1:0] hs_pipe;
    logic [PIPE_LAT-1:0] vs_pipe;

    // One action per falling edge of the combined strobe; a write masks a coincident read.
    assign wr_ev    = wr_prev & ~(CS_n | WR_n);
    assign rd_ev    = rd_prev & ~(CS_n | RD_n) & ~wr_ev;
    assign ct_we    = wr_ev && (A == 3'd5);
    assign cta_next = (cta == AW'(CT_DEPTH - 1)) ? '0 : cta + 1'b1;

    // Colour index 0 of any palette is transparent and falls through to the backdrop entry.
    assign vd_idx   = (VD[3:0] == 4'd0) ? 9'd0 : VD;

    assign DCC         = cr[1:0];
    assign HSYNC_out_n = hs_pipe[PIPE_LAT-1];
    assign VSYNC_out_n = vs_pipe[PIPE_LAT-1];

    // Reads sample the array before the write lands, so video sees old data on a collision.
    always_ff @(posedge clock) begin
        if (ct_we) begin
            ctram[cta] <= {DI[0], lo_stage};
        end
        pix_c    <= ctram[vd_idx[AW-1:0]];
        ram_b_q  <= ctram[cta];
        rd_latch <= ram_b_q;
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            cta      <= '0;
            lo_stage <= 8'h00;
            cr       <= 8'h00;
            DO       <= 8'hFF;
            wr_prev  <= 1'b1;
            rd_prev  <= 1'b1;
        end else begin
            wr_prev <= CS_n | WR_n;
            rd_prev <= CS_n | RD_n;
            if (wr_ev) begin
                case (A)
                    3'd0:    cr <= DI;
                    3'd2:    cta[7:0] <= DI;
                    3'd3:    cta[AW-1] <= DI[0];
                    3'd4:    lo_stage <= DI;
                    3'd5:    cta <= cta_next;
                    default: ;
                endcase
            end else if (rd_ev) begin
                case (A)
                    3'd4:    DO <= rd_latch[7:0];
                    3'd5: begin
                        DO  <= {7'h7F, rd_latch[8]};
                        cta <= cta_next;
                    end
                    default: DO <= 8'hFF;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            blank_q <= 1'b1;
            R       <= 3'd0;
            G       <= 3'd0;
            B       <= 3'd0;
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            blank_q <= ~HSYNC_n | ~VSYNC_n;
            hs_pipe <= {hs_pipe[PIPE_LAT-2:0], HSYNC_n};
            vs_pipe <= {vs_pipe[PIPE_LAT-2:0], VSYNC_n};
            if (blank_q) begin
                R <= 3'd0;
                G <= 3'd0;
                B <= 3'd0;
            end else if (cr[7]) begin
                R <= pix_c[8:6];
                G <= pix_c[8:6];
                B <= pix_c[8:6];
            end else begin
                R <= pix_c[5:3];
                G <= pix_c[8:6];
                B <= pix_c[2:0];
            end
        end
    end

endmodule

// File: tb/tb_vce_palette_huc6260.sv
// tb/tb_vce_palette_huc6260.sv - randomized self-checking bench for vce_palette_huc6260
module tb_vce_palette_huc6260;

    logic       clock   = 1'b0;
    logic       reset_N = 1'b0;
    logic       CS_n    = 1'b1;
    logic       WR_n    = 1'b1;
    logic       RD_n    = 1'b1;
    logic [2:0] A       = 3'd0;
    logic [7:0] DI      = 8'h00;
    logic [7:0] DO;
    logic [8:0] VD      = 9'd0;
    logic       HSYNC_n = 1'b1;
    logic       VSYNC_n = 1'b1;
    logic [2:0] R, G, B;
    logic       HSYNC_out_n, VSYNC_out_n;
    logic [1:0] DCC;

    vce_palette_huc6260 dut (
        .clock(clock), .reset_N(reset_N), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
        .A(A), .DI(DI), .DO(DO), .VD(VD), .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n),
        .R(R), .G(G), .B(B), .HSYNC_out_n(HSYNC_out_n), .VSYNC_out_n(VSYNC_out_n), .DCC(DCC)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: colour table, address pointer, staging byte, control register.
    logic [8:0]  ct [512];
    logic [8:0]  m_cta = 9'd0;
    logic [7:0]  m_lo  = 8'h00;
    logic [7:0]  m_cr  = 8'h00;
    logic [10:0] q [$];
    int          lowc;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_write(input logic [2:0] a, input logic [7:0] d);
        case (a)
            3'd0: m_cr = d;
            3'd2: m_cta[7:0] = d;
            3'd3: m_cta[8] = d[0];
            3'd4: m_lo = d;
            3'd5: begin
                ct[m_cta] = {d[0], m_lo};
                m_cta = m_cta + 9'd1;
            end
            default: ;
        endcase
    endtask

    function automatic logic [10:0] exp_pix(logic [8:0] vd, logic hs, logic vs);
        logic [8:0] c;
        logic [2:0] r, g, b;
        c = ct[(vd[3:0] == 4'd0) ? 9'd0 : vd];
        if (!hs || !vs) begin
            r = 3'd0; g = 3'd0; b = 3'd0;
        end else if (m_cr[7]) begin
            r = c[8:6]; g = c[8:6]; b = c[8:6];
        end else begin
            r = c[5:3]; g = c[8:6]; b = c[2:0];
        end
        return {r, g, b, hs, vs};
    endfunction

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        A = a; DI = d; CS_n = 1'b0; WR_n = 1'b0;
        m_write(a, d);
        tick();
        WR_n = 1'b1; CS_n = 1'b1;
        tick();
    endtask

    task automatic set_cta(input logic [8:0] addr);
        cpu_write(3'd2, addr[7:0]);
        cpu_write(3'd3, {7'd0, addr[8]});
    endtask

    task automatic cpu_read_chk(input string tag, input logic [2:0] a);
        logic [7:0] e;
        tick(); tick();
        case (a)
            3'd4: e = ct[m_cta][7:0];
            3'd5: begin
                e = {7'h7F, ct[m_cta][8]};
                m_cta = m_cta + 9'd1;
            end
            default: e = 8'hFF;
        endcase
        A = a; CS_n = 1'b0; RD_n = 1'b0;
        tick();
        RD_n = 1'b1; CS_n = 1'b1;
        chk(tag, {24'd0, DO}, {24'd0, e});
        tick();
    endtask

    task automatic step(input logic [8:0] vd, input logic hs, input logic vs);
        logic [10:0] e;
        VD = vd; HSYNC_n = hs; VSYNC_n = vs;
        q.push_back(exp_pix(vd, hs, vs));
        tick();
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("pixel", {21'd0, R, G, B, HSYNC_out_n, VSYNC_out_n}, {21'd0, e});
        end
    endtask

    task automatic pix_const(input string tag, input logic [8:0] vd, input logic [8:0] rgb);
        q.delete();
        step(vd, 1'b1, 1'b1);
        step(vd, 1'b1, 1'b1);
        chk(tag, {23'd0, R, G, B}, {23'd0, rgb});
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_do", {24'd0, DO}, 32'hFF);
        chk("rst_rgb", {23'd0, R, G, B}, 32'd0);
        chk("rst_sync", {30'd0, HSYNC_out_n, VSYNC_out_n}, 32'd3);
        chk("rst_dcc", {30'd0, DCC}, 32'd0);
        reset_N = 1'b1;
        tick();

        // Fill the whole table with random data; the pointer wraps back to 0
        set_cta(9'd0);
        for (int i = 0; i < 512; i++) begin
            cpu_write(3'd4, 8'($urandom));
            cpu_write(3'd5, 8'($urandom));
        end
        cpu_read_chk("fill_wrap_rd4", 3'd4);
        repeat (20) begin
            set_cta(9'($urandom_range(0, 511)));
            cpu_read_chk("rand_rd4", 3'd4);
            cpu_read_chk("rand_rd5", 3'd5);
            cpu_read_chk("rand_rd4_next", 3'd4);
        end

        // Load and read back one entry
        cpu_write(3'd2, 8'h10);
        cpu_write(3'd3, 8'h00);
        cpu_write(3'd4, 8'hC7);
        cpu_write(3'd5, 8'h01);
        cpu_read_chk("t1_cta_after_write", 3'd4);
        set_cta(9'h010);
        cpu_read_chk("t1_rd4", 3'd4);
        cpu_read_chk("t1_rd5", 3'd5);
        cpu_read_chk("t1_cta_after_read", 3'd4);
        cpu_read_chk("t1_unmapped_rd", 3'd1);

        // Lookup, including transparent index falling back to entry 0
        set_cta(9'h023);
        cpu_write(3'd4, 8'hC7);
        cpu_write(3'd5, 8'h01);
        set_cta(9'h000);
        cpu_write(3'd4, 8'h07);
        cpu_write(3'd5, 8'h00);
        pix_const("t2_vd023", 9'h023, 9'b000_111_111);
        pix_const("t2_vd020", 9'h020, 9'b000_000_111);

        // Wrap at the top of the table, then greyscale
        set_cta(9'h1FF);
        cpu_write(3'd4, 8'h00);
        cpu_write(3'd5, 8'h00);
        cpu_read_chk("t3_wrap_rd4", 3'd4);
        cpu_write(3'd0, 8'h80);
        pix_const("t3_grey", 9'h023, 9'b111_111_111);
        chk("t3_dcc", {30'd0, DCC}, 32'd0);

        // Random pixel stream with random syncs under a random control register
        cpu_write(3'd0, 8'($urandom));
        chk("rand_dcc", {30'd0, DCC}, {30'd0, m_cr[1:0]});
        q.delete();
        repeat (300) begin
            step(9'($urandom_range(0, 511)), $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        end
        cpu_write(3'd0, 8'h00);

        // Sync delay and blanking
        q.delete();
        lowc = 0;
        step(9'h023, 1'b1, 1'b1);
        step(9'h023, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(9'h023, !(i < 3), 1'b1);
            if (!HSYNC_out_n) lowc++;
        end
        chk("t4_hsync_low_cycles", lowc, 3);

        // Held-low write strobe acts once
        set_cta(9'h060);
        cpu_write(3'd4, 8'h33);
        A = 3'd5; DI = 8'h01; CS_n = 1'b0; WR_n = 1'b0;
        m_write(3'd5, 8'h01);
        repeat (5) tick();
        WR_n = 1'b1; CS_n = 1'b1;
        tick();
        cpu_write(3'd4, 8'h44);
        cpu_write(3'd5, 8'h00);
        set_cta(9'h060);
        for (int i = 0; i < 7; i++) begin
            cpu_read_chk("t5_hold_rd4", 3'd4);
            cpu_read_chk("t5_hold_rd5", 3'd5);
        end

        // Write/read collision on entry 0x23
        set_cta(9'h023);
        cpu_write(3'd4, 8'h38);
        q.delete();
        step(9'h023, 1'b1, 1'b1);
        A = 3'd5; DI = 8'h00; CS_n = 1'b0; WR_n = 1'b0;
        step(9'h023, 1'b1, 1'b1);
        m_write(3'd5, 8'h00);
        WR_n = 1'b1; CS_n = 1'b1;
        step(9'h023, 1'b1, 1'b1);
        chk("t5_collide_old", {23'd0, R, G, B}, {23'd0, 9'b000_111_111});
        step(9'h023, 1'b1, 1'b1);
        chk("t5_collide_new", {23'd0, R, G, B}, {23'd0, 9'b111_000_000});

        // Asynchronous reset mid-stream
        cpu_write(3'd0, 8'h03);
        chk("t6_dcc_before", {30'd0, DCC}, 32'd3);
        set_cta(9'h010);
        cpu_read_chk("t6_do_before", 3'd4);
        q.delete();
        for (int i = 0; i < 4; i++) step(9'h023, 1'b1, 1'b0);
        #2 reset_N = 1'b0;
        #1;
        chk("t6_rst_rgb", {23'd0, R, G, B}, 32'd0);
        chk("t6_rst_sync", {30'd0, HSYNC_out_n, VSYNC_out_n}, 32'd3);
        chk("t6_rst_do", {24'd0, DO}, 32'hFF);
        chk("t6_rst_dcc", {30'd0, DCC}, 32'd0);
        tick();
        reset_N = 1'b1;
        m_cta = 9'd0; m_lo = 8'h00; m_cr = 8'h00;
        q.delete();
        repeat (30) step(9'($urandom_range(0, 511)), 1'b1, 1'b1);
        cpu_read_chk("t6_cta_reset_rd4", 3'd4);
        cpu_write(3'd5, 8'h01);
        set_cta(9'h000);
        cpu_read_chk("t6_lo_reset_rd4", 3'd4);
        cpu_read_chk("t6_lo_reset_rd5", 3'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vce_palette_huc6260.md
Name: vce_palette_HuC6260

Overview:
Colour encoder downstream of the HuC6270 VDC. It consumes the 9-bit pixel bus VD plus HSYNC_n/VSYNC_n, and looks each pixel up in a 512-entry, 9-bit colour table RAM (CTRAM). It drives 3-bit R/G/B with syncs delayed to match. A CPU byte port, strobed like the VDC's, gives access to the control register, the colour table address (CTA) and the colour table data (CTD).

Parameters:
PIPE_LAT, 2, pixel-to-RGB latency in clocks; syncs are delayed by the same amount.
CT_DEPTH, 512, colour table entries; CTA is clog2(CT_DEPTH) bits.

Ports:
clock  in  1  system clock (pixel clock domain, same as VDC)
reset_N  in  1  asynchronous, active-low reset
CS_n  in  1  chip select
WR_n  in  1  CPU write strobe
RD_n  in  1  CPU read strobe
A  in  3  register select
DI  in  8  CPU write data
DO  out  8  CPU read data
VD  in  9  pixel from VDC: [8]=sprite/BG select, [7:4] palette, [3:0] colour index
HSYNC_n  in  1  from VDC
VSYNC_n  in  1  from VDC
R  out  3  red
G  out  3  green
B  out  3  blue
HSYNC_out_n  out  1  HSYNC_n delayed PIPE_LAT
VSYNC_out_n  out  1  VSYNC_n delayed PIPE_LAT
DCC  out  2  dot-clock select, CR[1:0]

Behaviour:
- Reset (async) values:
  - CTA=0, lo_stage=0, CR=0, DO=8'hFF.
  - R=G=B=0; HSYNC_out_n=VSYNC_out_n=1; sync delay stages all 1.
  - Strobe history = inactive.
  - CTRAM contents are not cleared.
- CPU strobes:
  - wr_ev = registered (CS_n|WR_n) was 1 and the current value is 0. Exactly one action per falling edge; a held-low strobe acts once.
  - rd_ev is the same rule using RD_n.
  - wr_ev and rd_ev in the same cycle: the write takes effect and the read is ignored.
- Register map, writes:
  - A=0: CR<=DI (DCC=CR[1:0], CR[7]=greyscale).
  - A=2: CTA[7:0]<=DI.
  - A=3: CTA[8]<=DI[0].
  - A=4: lo_stage<=DI.
  - A=5: CTRAM[CTA]<={DI[0],lo_stage}, then CTA<=CTA+1; 511 wraps to 0.
  - A=1,6,7: ignored.
- Register map, reads:
  - A=4: DO<=rd_latch[7:0].
  - A=5: DO<={7'h7F,rd_latch[8]}, then CTA<=CTA+1 with wrap.
  - All other A: DO<=8'hFF.
  - DO is registered and holds until the next rd_ev.
- rd_latch:
  - CTRAM port B reads CTA every cycle; rd_latch updates the cycle after.
  - rd_latch is valid 2 clocks after any CTA change or CTD write. The CPU never reads sooner.
- Video path, stage 0:
  - idx = (VD[3:0]==0) ? 9'd0 : VD.
  - Transparent pixels, and the VD=0 the VDC drives outside active display, show entry 0 (backdrop).
  - Port A is read at idx.
- Video path, stage 1:
  - c = CTRAM data, format {G[8:6],R[5:3],B[2:0]}.
  - If the registered blank is set, where blank = ~HSYNC_n | ~VSYNC_n captured at stage 0, then R=G=B=0.
  - Else if CR[7]=1, R=G=B=c[8:6].
  - Else R=c[5:3], G=c[8:6], B=c[2:0].
- Latency: VD at edge n appears on RGB after edge n+2. Syncs use a matching 2-deep shift register.
- Port collision: a CPU write to entry X and a video read of X in the same cycle gives video the old data (read-before-write). The new data is visible on the next read.
- CR changes affect RGB starting with the pixel in stage 1 on the cycle after the write.
- Reset mid-line: outputs go immediately to reset values. The pipeline refills; the first valid RGB is 2 clocks after deassertion.

Test Plan:
1. Load: A=2 <- 8'h10, A=3 <- 8'h00, A=4 <- 8'hC7, A=5 <- 8'h01. Required: CTRAM[0x10]=9'h1C7 and CTA=0x011. Set CTA=0x010, wait 2 clocks, read A=4 -> 8'hC7; read A=5 -> 8'hFF; CTA is then 0x011.
2. Lookup: CTRAM[0x23]=9'h1C7 and CTRAM[0]=9'h007; syncs high. Drive VD=9'h023 at edge n -> R=0, G=7, B=7 after edge n+2. VD=9'h020 -> entry 0 -> R=0, G=0, B=7.
3. Wrap and greyscale: set CTA=0x1FF, write A=4 <- 8'h00, A=5 <- 8'h00 -> CTA=0. Write CR=8'h80 and show VD=9'h023 -> R=G=B=7. Confirm DCC=0.
4. Sync/blank: drive HSYNC_n low for 3 cycles with VD=9'h023 -> HSYNC_out_n low for exactly those 3 cycles shifted by 2, with R=G=B=0 for the same 3 cycles.
5. Strobe edge and collision: hold WR_n low 5 cycles on A=5 -> CTA advances by 1 only. Write entry 0x23 while VD=9'h023 in the same cycle -> RGB shows the old colour, then the new colour on the next pixel.
6. Async reset mid-stream: pulse reset_N low mid-line -> RGB=0, syncs=1, DO=8'hFF immediately. After release, the previously loaded CTRAM contents still render.
